// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the reg_bank_ctx register group and its context-save FSM.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSave,
    StIsr,
    StRestore
  } ctx_state_e;

  localparam logic [63:0] RegRstVal = 64'h0;

endpackage

// File: rtl/reg_bank_shadow.sv
// Single-port shadow storage for interrupt context: one write or one combinational read per cycle.
module reg_bank_shadow #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 9,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/reg_bank_ctx.sv
// NREG GPRs plus FLAG/PC/IPC/SYS with hardware interrupt context save/restore.
// Optional same-cycle write-back bypass on reads: define REG_BANK_BYPASS_EN.
module reg_bank_ctx
  import reg_bank_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NREG     = 8,
  parameter int unsigned RD_PORTS = 2,
  parameter int unsigned WR_PORTS = 2,
  parameter int unsigned AW       = $clog2(NREG + 1)
) (
  input  logic                         clk,
  input  logic                         all_rst,
  input  logic [RD_PORTS*AW-1:0]       rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  input  logic [WR_PORTS-1:0]          wb_en,
  input  logic [WR_PORTS*AW-1:0]       wb_addr,
  input  logic [WR_PORTS*DATA_W-1:0]   wb_data,
  input  logic                         flag_wen,
  input  logic [DATA_W-1:0]            flag_wdata,
  input  logic                         sys_wen,
  input  logic [DATA_W-1:0]            sys_wdata,
  input  logic                         ipc_wen,
  input  logic [DATA_W-1:0]            ipc_wdata,
  input  logic [DATA_W-1:0]            next_pc,
  input  logic                         pc_stop,
  input  logic                         intr_req,
  input  logic [DATA_W-1:0]            intr_pc,
  input  logic [DATA_W-1:0]            intr_ipc,
  input  logic                         iret_req,
  output logic                         intr_ack,
  output logic                         ctx_busy,
  output logic                         in_isr,
  output logic [DATA_W-1:0]            flag,
  output logic [DATA_W-1:0]            pc,
  output logic [DATA_W-1:0]            ipc,
  output logic [DATA_W-1:0]            sys
);

  localparam logic [DATA_W-1:0] RstVal = DATA_W'(RegRstVal);

  ctx_state_e        state_q;
  logic [AW-1:0]     idx_q;
  logic              intr_ack_q, ctx_busy_q, in_isr_q;
  logic [DATA_W-1:0] gpr_q [NREG];
  logic [DATA_W-1:0] gpr_d [NREG];
  logic [DATA_W-1:0] flag_q, flag_d, pc_q, pc_d, ipc_q, ipc_d, sys_q, sys_d;
  logic [DATA_W-1:0] sh_wdata, sh_rdata;
  logic              idx_last, enter, normal;

  assign idx_last = (idx_q == AW'(NREG));
  assign enter    = (state_q == StIdle) && intr_req;
  assign normal   = ((state_q == StIdle) && !intr_req) || (state_q == StIsr);

  always_ff @(posedge clk) begin
    if (all_rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      intr_ack_q <= 1'b0;
      ctx_busy_q <= 1'b0;
      in_isr_q   <= 1'b0;
    end else begin
      intr_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (intr_req) begin
            state_q    <= StSave;
            idx_q      <= '0;
            intr_ack_q <= 1'b1;
            ctx_busy_q <= 1'b1;
          end
        end
        StSave: begin
          if (idx_last) begin
            state_q    <= StIsr;
            ctx_busy_q <= 1'b0;
            in_isr_q   <= 1'b1;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        StIsr: begin
          if (iret_req) begin
            state_q    <= StRestore;
            idx_q      <= '0;
            ctx_busy_q <= 1'b1;
            in_isr_q   <= 1'b0;
          end
        end
        StRestore: begin
          if (idx_last) begin
            state_q    <= StIdle;
            ctx_busy_q <= 1'b0;
          end else begin
            idx_q <= idx_q + AW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Shadow entry i < NREG holds GPR i+1; entry NREG holds FLAG.
  always_comb begin
    sh_wdata = flag_q;
    for (int r = 0; r < NREG; r++) begin
      if (idx_q == AW'(r)) sh_wdata = gpr_q[r];
    end
  end

  reg_bank_shadow #(
    .DATA_W (DATA_W),
    .DEPTH  (NREG + 1),
    .AW     (AW)
  ) u_shadow (
    .clk_i   (clk),
    .we_i    (state_q == StSave),
    .addr_i  (idx_q),
    .wdata_i (sh_wdata),
    .rdata_o (sh_rdata)
  );

  always_comb begin
    gpr_d  = gpr_q;
    flag_d = flag_q;
    ipc_d  = ipc_q;
    sys_d  = sys_wen ? sys_wdata : sys_q;
    pc_d   = pc_stop ? pc_q : next_pc;
    if (normal) begin
      // Walk ports high to low so the lowest index lands last and wins.
      for (int p = WR_PORTS - 1; p >= 0; p--) begin
        for (int r = 0; r < NREG; r++) begin
          if (wb_en[p] && (wb_addr[p*AW +: AW] == AW'(r + 1))) gpr_d[r] = wb_data[p*DATA_W +: DATA_W];
        end
      end
      if (flag_wen) flag_d = flag_wdata;
      if (ipc_wen)  ipc_d  = ipc_wdata;
    end
    if (enter) begin
      pc_d  = intr_pc;
      ipc_d = intr_ipc;
      sys_d = RstVal;
    end
    if (ctx_busy_q) pc_d = pc_q;
    if (state_q == StRestore) begin
      for (int r = 0; r < NREG; r++) begin
        if (idx_q == AW'(r)) gpr_d[r] = sh_rdata;
      end
      if (idx_last) begin
        flag_d = sh_rdata;
        pc_d   = ipc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (all_rst) begin
      for (int r = 0; r < NREG; r++) gpr_q[r] <= RstVal;
      flag_q <= RstVal;
      pc_q   <= RstVal;
      ipc_q  <= RstVal;
      sys_q  <= RstVal;
    end else begin
      gpr_q  <= gpr_d;
      flag_q <= flag_d;
      pc_q   <= pc_d;
      ipc_q  <= ipc_d;
      sys_q  <= sys_d;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < RD_PORTS; k++) begin
      for (int r = 0; r < NREG; r++) begin
        if (rd_addr[k*AW +: AW] == AW'(r + 1)) rd_data[k*DATA_W +: DATA_W] = gpr_q[r];
      end
`ifdef REG_BANK_BYPASS_EN
      for (int p = WR_PORTS - 1; p >= 0; p--) begin
        if (!ctx_busy_q && wb_en[p] && (wb_addr[p*AW +: AW] == rd_addr[k*AW +: AW]) &&
            (rd_addr[k*AW +: AW] != '0) && (rd_addr[k*AW +: AW] <= AW'(NREG))) begin
          rd_data[k*DATA_W +: DATA_W] = wb_data[p*DATA_W +: DATA_W];
        end
      end
`endif
    end
  end

`ifdef REG_BANK_BYPASS_EN
  assign flag = (flag_wen && !ctx_busy_q) ? flag_wdata : flag_q;
`else
  assign flag = flag_q;
`endif

  assign pc       = pc_q;
  assign ipc      = ipc_q;
  assign sys      = sys_q;
  assign intr_ack = intr_ack_q;
  assign ctx_busy = ctx_busy_q;
  assign in_isr   = in_isr_q;

endmodule

// File: tb/tb_reg_bank_ctx.sv
// Randomized bench for reg_bank_ctx checked against a transaction-level context-switch model.
module tb_reg_bank_ctx;
  localparam int DATA_W = 32, NREG = 8, RD_PORTS = 2, WR_PORTS = 2;
  localparam int AW = $clog2(NREG + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       all_rst;
  logic [RD_PORTS*AW-1:0]     rd_addr;
  logic [RD_PORTS*DATA_W-1:0] rd_data;
  logic [WR_PORTS-1:0]        wb_en;
  logic [WR_PORTS*AW-1:0]     wb_addr;
  logic [WR_PORTS*DATA_W-1:0] wb_data;
  logic                       flag_wen, sys_wen, ipc_wen, pc_stop, intr_req, iret_req;
  logic [DATA_W-1:0]          flag_wdata, sys_wdata, ipc_wdata, next_pc, intr_pc, intr_ipc;
  logic                       intr_ack, ctx_busy, in_isr;
  logic [DATA_W-1:0]          flag, pc, ipc, sys;

  reg_bank_ctx #(
    .DATA_W   (DATA_W),
    .NREG     (NREG),
    .RD_PORTS (RD_PORTS),
    .WR_PORTS (WR_PORTS)
  ) dut (
    .clk        (clk),
    .all_rst    (all_rst),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .flag_wen   (flag_wen),
    .flag_wdata (flag_wdata),
    .sys_wen    (sys_wen),
    .sys_wdata  (sys_wdata),
    .ipc_wen    (ipc_wen),
    .ipc_wdata  (ipc_wdata),
    .next_pc    (next_pc),
    .pc_stop    (pc_stop),
    .intr_req   (intr_req),
    .intr_pc    (intr_pc),
    .intr_ipc   (intr_ipc),
    .iret_req   (iret_req),
    .intr_ack   (intr_ack),
    .ctx_busy   (ctx_busy),
    .in_isr     (in_isr),
    .flag       (flag),
    .pc         (pc),
    .ipc        (ipc),
    .sys        (sys)
  );

  // Model: mode 0 idle, 1 saving, 2 in handler, 3 restoring; a busy phase lasts NREG+1 cycles.
  int          n_cmp = 0, n_bad = 0;
  int          m_mode, m_left;
  logic [31:0] m_gpr [NREG+1];
  logic [31:0] m_sh_gpr [NREG+1];
  logic [31:0] m_flag, m_sh_flag, m_pc, m_ipc, m_sys;
  logic        m_ack;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_busy();
    return (m_mode == 1) || (m_mode == 3);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [AW-1:0] a);
    logic [31:0] v;
    v = 32'h0;
    if (a >= 1 && a <= NREG) v = m_gpr[a];
`ifdef REG_BANK_BYPASS_EN
    if (!m_busy() && a >= 1 && a <= NREG)
      for (int p = WR_PORTS - 1; p >= 0; p--)
        if (wb_en[p] && wb_addr[p*AW +: AW] == a) v = wb_data[p*DATA_W +: DATA_W];
`endif
    return v;
  endfunction

  function automatic logic [31:0] exp_flag();
`ifdef REG_BANK_BYPASS_EN
    if (flag_wen && !m_busy()) return flag_wdata;
`endif
    return m_flag;
  endfunction

  task automatic model_edge();
    bit            busy, open;
    bit [NREG:0]   done;
    int            a;
    if (all_rst) begin
      for (int i = 0; i <= NREG; i++) m_gpr[i] = 0;
      m_flag = 0; m_pc = 0; m_ipc = 0; m_sys = 0; m_mode = 0; m_ack = 0; m_left = 0;
      return;
    end
    busy  = m_busy();
    open  = (m_mode == 0 && !intr_req) || m_mode == 2;
    m_ack = (m_mode == 0) && intr_req;
    done  = '0;
    if (open) begin
      for (int p = 0; p < WR_PORTS; p++) begin
        a = int'(wb_addr[p*AW +: AW]);
        if (wb_en[p] && a >= 1 && a <= NREG && !done[a]) begin
          m_gpr[a] = wb_data[p*DATA_W +: DATA_W];
          done[a]  = 1'b1;
        end
      end
      if (flag_wen) m_flag = flag_wdata;
      if (ipc_wen)  m_ipc  = ipc_wdata;
    end
    if (sys_wen) m_sys = sys_wdata;
    if (!busy && !pc_stop) m_pc = next_pc;
    case (m_mode)
      0: if (intr_req) begin
        m_pc = intr_pc; m_ipc = intr_ipc; m_sys = 0;
        m_mode = 1; m_left = NREG + 1;
        m_sh_gpr = m_gpr; m_sh_flag = m_flag;
      end
      1: begin
        m_left--;
        if (m_left == 0) m_mode = 2;
      end
      2: if (iret_req) begin
        m_mode = 3; m_left = NREG + 1;
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          m_gpr = m_sh_gpr; m_flag = m_sh_flag; m_pc = m_ipc; m_mode = 0;
        end
      end
    endcase
  endtask

  task automatic check_all();
    check_eq("intr_ack", 32'(intr_ack), 32'(m_ack));
    check_eq("ctx_busy", 32'(ctx_busy), 32'(m_busy()));
    check_eq("in_isr", 32'(in_isr), 32'(m_mode == 2));
    check_eq("pc", pc, m_pc);
    check_eq("ipc", ipc, m_ipc);
    check_eq("sys", sys, m_sys);
    check_eq("flag", flag, exp_flag());
    if (!m_busy())
      for (int k = 0; k < RD_PORTS; k++)
        check_eq($sformatf("rd_data[%0d]@%0d", k, rd_addr[k*AW +: AW]),
                 rd_data[k*DATA_W +: DATA_W], exp_rd(rd_addr[k*AW +: AW]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    all_rst = 0; wb_en = '0; wb_addr = '0; wb_data = '0;
    flag_wen = 0; sys_wen = 0; ipc_wen = 0; pc_stop = 1; intr_req = 0; iret_req = 0;
    flag_wdata = 0; sys_wdata = 0; ipc_wdata = 0; next_pc = 0; intr_pc = 0; intr_ipc = 0;
  endtask

  task automatic wb(input int port, input int addr, input logic [31:0] data);
    wb_en[port] = 1'b1;
    wb_addr[port*AW +: AW] = AW'(addr);
    wb_data[port*DATA_W +: DATA_W] = data;
  endtask

  initial begin
    idle_inputs();
    rd_addr = '0;
    all_rst = 1;
    step(); step();
    all_rst = 0;
    for (int a = 0; a <= NREG + 2; a++) begin
      rd_addr = {AW'(a), AW'(a)};
      #1;
      check_eq("reset_rd0", rd_data[0 +: DATA_W], 32'h0);
      check_eq("reset_rd1", rd_data[DATA_W +: DATA_W], 32'h0);
    end

    // r3 via port 0, read on port 1
    wb(0, 3, 32'h1234); rd_addr = {AW'(3), AW'(0)};
    step();
    idle_inputs();
    step();

    // both ports on r5: port 0 wins
    wb(0, 5, 32'hAAAA); wb(1, 5, 32'hBBBB); rd_addr = {AW'(5), AW'(5)};
    step();
    idle_inputs();
    step();

    // r1..r8 = 1..8, flag = 0xF
    for (int i = 1; i <= NREG; i += 2) begin
      wb(0, i, 32'(i)); wb(1, i + 1, 32'(i + 1));
      step();
    end
    idle_inputs();
    flag_wen = 1; flag_wdata = 32'hF;
    step();
    idle_inputs();

    // entry, with a write-back in the entry cycle and during SAVE
    intr_req = 1; intr_pc = 32'h100; intr_ipc = 32'h40; wb(0, 2, 32'hDEAD);
    step();
    idle_inputs();
    for (int c = 0; c < NREG + 1; c++) begin
      wb(0, 4, 32'hBEEF); flag_wen = 1; flag_wdata = 32'h77;
      step();
    end
    idle_inputs();
    pc_stop = 0; next_pc = 32'h104;
    step();

    // handler clobbers registers; nested intr_req ignored
    for (int i = 1; i <= NREG; i += 2) begin
      wb(0, i, 32'hFF); wb(1, i + 1, 32'hFF); intr_req = 1;
      step();
    end
    idle_inputs();
    iret_req = 1;
    step();
    idle_inputs();
    for (int c = 0; c < NREG + 2; c++) begin
      rd_addr = {AW'(c % NREG + 1), AW'((c + 3) % NREG + 1)};
      step();
    end

    // reset on the 4th SAVE cycle
    intr_req = 1; intr_pc = 32'h200; intr_ipc = 32'h80;
    step();
    idle_inputs();
    step(); step(); step();
    all_rst = 1;
    step();
    idle_inputs();
    step();

    for (int c = 0; c < 3000; c++) begin
      all_rst    = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < WR_PORTS; p++) begin
        wb_en[p] = 1'($urandom);
        wb_addr[p*AW +: AW] = AW'($urandom_range(0, NREG + 2));
        wb_data[p*DATA_W +: DATA_W] = $urandom;
      end
      for (int k = 0; k < RD_PORTS; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(0, NREG + 2));
      flag_wen   = ($urandom_range(0, 3) == 0); flag_wdata = $urandom;
      sys_wen    = ($urandom_range(0, 7) == 0); sys_wdata  = $urandom;
      ipc_wen    = ($urandom_range(0, 7) == 0); ipc_wdata  = $urandom;
      pc_stop    = ($urandom_range(0, 3) == 0); next_pc    = $urandom;
      intr_req   = ($urandom_range(0, 19) == 0);
      intr_pc    = $urandom; intr_ipc = $urandom;
      iret_req   = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
